axil_regfile: RTL and testbench
===============================

# axil_regfile

Parametrised AXI4-Lite slave register file, successor to the fixed 4-control/2-status DMA control interface. It exposes C_NUM_CTRL read/write control registers and C_NUM_STAT read-only status registers to PL logic. It accepts AW and W independently, honours WSTRB, and flags unmapped accesses. It sits between the PS AXI-Lite master port and the MIPS/DMA control logic.

## Interface
- C_DATA_WIDTH, 32: data width; 32 or 64.
- C_ADDR_WIDTH, 6: byte address width; must satisfy 2^C_ADDR_WIDTH ≥ (C_NUM_CTRL+C_NUM_STAT)·C_DATA_WIDTH/8.
- C_NUM_CTRL, 4: number of control registers, 1..16.
- C_NUM_STAT, 2: number of status registers, 0..16.
- S_ACLK  in  1  clock; the only clock.
- S_ARESET  in  1  synchronous, active-high reset.
- CTRL  out  C_NUM_CTRL·C_DATA_WIDTH  control register contents; register i occupies bits [i·C_DATA_WIDTH +: C_DATA_WIDTH].
- CTRL_WR  out  C_NUM_CTRL  one-cycle pulse per control register on commit.
- STAT  in  C_NUM_STAT·C_DATA_WIDTH  status inputs, packed the same way as CTRL.
- S_AWADDR/S_AWPROT/S_AWVALID/S_AWREADY, S_WDATA/S_WSTRB/S_WVALID/S_WREADY, S_BRESP/S_BVALID/S_BREADY, S_ARADDR/S_ARPROT/S_ARVALID/S_ARREADY, S_RDATA/S_RRESP/S_RVALID/S_RREADY: standard AXI4-Lite slave channels. Widths come from C_ADDR_WIDTH and C_DATA_WIDTH. PROT is ignored.

## Operation
- Address decode: word index = addr >> log2(C_DATA_WIDTH/8); low address bits are ignored.
  - Index 0..C_NUM_CTRL-1 selects a control register.
  - Index C_NUM_CTRL..C_NUM_CTRL+C_NUM_STAT-1 selects a status register.
  - Any other index is unmapped.
- Write channel, two independent capture flags aw_held and w_held:
  - S_AWREADY = !aw_held && !S_BVALID.
  - S_WREADY = !w_held && !S_BVALID.
  - An AW handshake sets aw_held and latches the address. A W handshake sets w_held and latches data and strobe.
- Write commit happens on the edge where address and data are each either held or handshaking on that edge.
  - Control target: for each byte lane b with WSTRB[b]=1, the lane takes the new data. Lanes with WSTRB[b]=0 keep their value.
  - Control target: CTRL_WR[i] pulses for one cycle, even when WSTRB=0.
  - Status target: the write is discarded and BRESP=OKAY.
  - Unmapped target: the write is discarded; BRESP as described under Configuration.
  - The same edge clears both flags and sets S_BVALID.
- S_BVALID stays high until the edge where S_BREADY is sampled high. No new AW or W is accepted while it is high.
- Read channel: S_ARREADY = !S_RVALID.
  - On an AR handshake, S_RDATA and S_RRESP are registered and S_RVALID goes high on the next cycle.
  - S_RVALID, S_RDATA and S_RRESP are held until the RREADY handshake.
  - STAT is sampled on the AR handshake edge.
- Simultaneous read and commit to the same control register: the read returns the pre-write value.
- The read and write paths are fully independent and may handshake on the same edge.

## Timing
- Reset values (S_ARESET high at an edge):
  - CTRL = 0, CTRL_WR = 0.
  - S_BVALID = 0, S_RVALID = 0, S_RDATA = 0, S_BRESP = 0, S_RRESP = 0.
  - aw_held = w_held = 0.
  - Readies therefore read 1 in the first cycle after reset, and also during reset (combinational from cleared state). The master must not drive VALID during reset.
- AW and W valid together in cycle 0: commit at the end of cycle 0. CTRL and CTRL_WR update and S_BVALID=1 in cycle 1.
- AW in cycle 0, W in cycle 3: commit at the end of cycle 3; S_BVALID=1 in cycle 4.
- B back-pressure: readies stay 0 until the cycle after B completes.
- Read latency: AR handshake in cycle n gives S_RVALID=1 in cycle n+1. Maximum throughput is one read per 2 cycles with RREADY tied high. Writes follow the same limit, one per 2 cycles.
- Reset mid-transaction: all held state and pending responses are dropped with no response. CTRL returns to 0.

## Configuration
- AXIL_REGFILE_SLVERR_EN defined: unmapped reads and writes return RESP=2'b10 (SLVERR), and unmapped reads return RDATA=0.
- AXIL_REGFILE_SLVERR_EN undefined: every access returns OKAY (2'b00), and unmapped reads return 0.

## Structure
- Package axil_regfile_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - A clog2 function.
  - The byte-lane merge function (old, new, strb) used for the strobed write.
- Sub-module axil_regfile_wr_ch contains the AW/W capture flags, the commit strobe and the B-channel state. It outputs the commit strobe, latched address, data and strobe to the register array in the top module.

## Test plan
- Reset, then write 0x12345678 to 0x00 with AW and W in the same cycle → CTRL[0]=0x12345678 and CTRL_WR=4'b0001 in cycle 1; BVALID=1 with BRESP=00.
- AW to 0x08 in cycle 0, W 0xAABBCCDD with WSTRB=4'b0101 in cycle 3, on top of prior value 0 → CTRL[2]=0x00BB00DD; BVALID rises in cycle 4.
- BREADY held low for 5 cycles after a write → BVALID stays 1 and AWREADY/WREADY stay 0 throughout; a second AW issued meanwhile is accepted only after B completes.
- STAT[0]=0xCAFE0001 and C_NUM_CTRL=4; read 0x10 → RDATA=0xCAFE0001, RRESP=00, RVALID one cycle after AR. Write 0xFFFFFFFF to 0x10 → no CTRL change, BRESP=00.
- Read of CTRL[1] and write of 0x5 to CTRL[1] on the same edge → RDATA returns the old value; a subsequent read returns 0x5.
- With AXIL_REGFILE_SLVERR_EN, read and write of 0x1C (index 7) → RRESP=BRESP=10 and RDATA=0. Without the macro, both responses are 00.

Source files
------------

// File: rtl/axil_regfile_pkg.sv
// Shared constants and helpers for the AXI4-Lite register file.
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         MAX_DW      = 64;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v / 2) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Byte-lane merge at the widest supported width; callers zero-extend and slice.
  function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_v,
                                                    input logic [MAX_DW-1:0] new_v,
                                                    input logic [MAX_DW/8-1:0] strb);
    logic [MAX_DW-1:0] res;
    res = old_v;
    for (int b = 0; b < MAX_DW / 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regfile_wr_ch.sv
// AXI4-Lite write channel: independent AW/W capture, commit strobe and B response.
module axil_regfile_wr_ch
  import axil_regfile_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [C_ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                      i_awvalid,
  output logic                      o_awready,
  input  logic [C_DATA_WIDTH-1:0]   i_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  input  logic [1:0]                i_resp,
  output logic [1:0]                o_bresp,
  output logic                      o_bvalid,
  input  logic                      i_bready,
  output logic                      o_commit,
  output logic [C_ADDR_WIDTH-1:0]   o_addr,
  output logic [C_DATA_WIDTH-1:0]   o_data,
  output logic [C_DATA_WIDTH/8-1:0] o_strb
);

  logic                      r_aw_held;
  logic                      r_w_held;
  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic [C_ADDR_WIDTH-1:0]   r_addr;
  logic [C_DATA_WIDTH-1:0]   r_data;
  logic [C_DATA_WIDTH/8-1:0] r_strb;
  logic                      w_aw_hs;
  logic                      w_w_hs;

  assign o_awready = !r_aw_held && !r_bvalid;
  assign o_wready  = !r_w_held && !r_bvalid;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign w_aw_hs   = i_awvalid && o_awready;
  assign w_w_hs    = i_wvalid && o_wready;

  // A half that handshakes on the commit edge is forwarded directly, bypassing the latch.
  always_comb begin
    o_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    o_addr   = r_aw_held ? r_addr : i_awaddr;
    o_data   = r_w_held ? r_data : i_wdata;
    o_strb   = r_w_held ? r_strb : i_wstrb;
  end

  // Capture flags, latched AW/W payload and B response state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_addr    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
    end else begin
      if (w_aw_hs) begin
        r_addr <= i_awaddr;
      end
      if (w_w_hs) begin
        r_data <= i_wdata;
        r_strb <= i_wstrb;
      end
      if (o_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= i_resp;
      end else begin
        r_aw_held <= r_aw_held || w_aw_hs;
        r_w_held  <= r_w_held || w_w_hs;
        if (r_bvalid && i_bready) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/axil_regfile.sv
// Parametrised AXI4-Lite control/status register file.
// Define AXIL_REGFILE_SLVERR_EN to answer unmapped accesses with SLVERR.
module axil_regfile
  import axil_regfile_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_NUM_CTRL   = 4,
  parameter int C_NUM_STAT   = 2
) (
  input  logic                                              S_ACLK,
  input  logic                                              S_ARESET,
  output logic [C_NUM_CTRL*C_DATA_WIDTH-1:0]                CTRL,
  output logic [C_NUM_CTRL-1:0]                             CTRL_WR,
  input  logic [((C_NUM_STAT > 0) ? C_NUM_STAT : 1)*C_DATA_WIDTH-1:0] STAT,
  input  logic [C_ADDR_WIDTH-1:0]                           S_AWADDR,
  input  logic [2:0]                                        S_AWPROT,
  input  logic                                              S_AWVALID,
  output logic                                              S_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]                           S_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]                         S_WSTRB,
  input  logic                                              S_WVALID,
  output logic                                              S_WREADY,
  output logic [1:0]                                        S_BRESP,
  output logic                                              S_BVALID,
  input  logic                                              S_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]                           S_ARADDR,
  input  logic [2:0]                                        S_ARPROT,
  input  logic                                              S_ARVALID,
  output logic                                              S_ARREADY,
  output logic [C_DATA_WIDTH-1:0]                           S_RDATA,
  output logic [1:0]                                        S_RRESP,
  output logic                                              S_RVALID,
  input  logic                                              S_RREADY
);

  localparam int NB       = C_DATA_WIDTH / 8;
  localparam int ADDR_LSB = clog2(NB);
  localparam int NUM_REGS = C_NUM_CTRL + C_NUM_STAT;

  logic [C_DATA_WIDTH-1:0]   r_ctrl [C_NUM_CTRL];
  logic [C_NUM_CTRL-1:0]     r_ctrl_wr;
  logic                      r_rvalid;
  logic [C_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                r_rresp;

  logic                      w_commit;
  logic [C_ADDR_WIDTH-1:0]   w_wr_addr;
  logic [C_DATA_WIDTH-1:0]   w_wr_data;
  logic [NB-1:0]             w_wr_strb;
  logic [1:0]                w_wr_resp;
  logic [31:0]               w_wr_idx;
  logic [31:0]               w_rd_idx;
  logic                      w_ar_hs;
  logic [C_DATA_WIDTH-1:0]   w_rd_data;
  logic [1:0]                w_rd_resp;
  logic [MAX_DW-1:0]         w_old64;
  logic [MAX_DW-1:0]         w_new64;
  logic [MAX_DW/8-1:0]       w_strb64;
  logic [MAX_DW-1:0]         w_merged64;
  logic                      w_unused_ok;

  axil_regfile_wr_ch #(
    .C_DATA_WIDTH(C_DATA_WIDTH),
    .C_ADDR_WIDTH(C_ADDR_WIDTH)
  ) u_wr_ch (
    .i_clk    (S_ACLK),
    .i_rst    (S_ARESET),
    .i_awaddr (S_AWADDR),
    .i_awvalid(S_AWVALID),
    .o_awready(S_AWREADY),
    .i_wdata  (S_WDATA),
    .i_wstrb  (S_WSTRB),
    .i_wvalid (S_WVALID),
    .o_wready (S_WREADY),
    .i_resp   (w_wr_resp),
    .o_bresp  (S_BRESP),
    .o_bvalid (S_BVALID),
    .i_bready (S_BREADY),
    .o_commit (w_commit),
    .o_addr   (w_wr_addr),
    .o_data   (w_wr_data),
    .o_strb   (w_wr_strb)
  );

  assign w_unused_ok = &{1'b0, S_AWPROT, S_ARPROT, S_ARADDR[ADDR_LSB-1:0], w_wr_addr[ADDR_LSB-1:0]};

  assign w_wr_idx  = 32'(w_wr_addr[C_ADDR_WIDTH-1:ADDR_LSB]);
  assign w_rd_idx  = 32'(S_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB]);
  assign S_ARREADY = !r_rvalid;
  assign w_ar_hs   = S_ARVALID && S_ARREADY;
  assign S_RVALID  = r_rvalid;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = r_rresp;
  assign CTRL_WR   = r_ctrl_wr;

  for (genvar g = 0; g < C_NUM_CTRL; g++) begin : g_ctrl_out
    assign CTRL[g*C_DATA_WIDTH +: C_DATA_WIDTH] = r_ctrl[g];
  end

  // Write response decode and strobed merge for the addressed control register.
  always_comb begin
`ifdef AXIL_REGFILE_SLVERR_EN
    w_wr_resp = (w_wr_idx >= 32'(NUM_REGS)) ? RESP_SLVERR : RESP_OKAY;
`else
    w_wr_resp = RESP_OKAY;
`endif
    w_old64  = '0;
    w_new64  = '0;
    w_strb64 = '0;
    for (int i = 0; i < C_NUM_CTRL; i++) begin
      w_old64[C_DATA_WIDTH-1:0] = w_old64[C_DATA_WIDTH-1:0] |
                                  ((w_wr_idx == 32'(i)) ? r_ctrl[i] : '0);
    end
    w_new64[C_DATA_WIDTH-1:0] = w_wr_data;
    w_strb64[NB-1:0]          = w_wr_strb;
    w_merged64                = merge_bytes(w_old64, w_new64, w_strb64);
  end

  // Read decode: control, status, or zero for unmapped.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < C_NUM_CTRL; i++) begin
      w_rd_data = w_rd_data | ((w_rd_idx == 32'(i)) ? r_ctrl[i] : '0);
    end
    for (int j = 0; j < C_NUM_STAT; j++) begin
      w_rd_data = w_rd_data |
                  ((w_rd_idx == 32'(C_NUM_CTRL + j)) ? STAT[j*C_DATA_WIDTH +: C_DATA_WIDTH] : '0);
    end
`ifdef AXIL_REGFILE_SLVERR_EN
    w_rd_resp = (w_rd_idx >= 32'(NUM_REGS)) ? RESP_SLVERR : RESP_OKAY;
`else
    w_rd_resp = RESP_OKAY;
`endif
  end

  // Control register array and commit pulses.
  always_ff @(posedge S_ACLK) begin
    if (S_ARESET) begin
      for (int i = 0; i < C_NUM_CTRL; i++) begin
        r_ctrl[i] <= '0;
      end
      r_ctrl_wr <= '0;
    end else begin
      for (int i = 0; i < C_NUM_CTRL; i++) begin
        if (w_commit && (w_wr_idx == 32'(i))) begin
          r_ctrl[i]    <= w_merged64[C_DATA_WIDTH-1:0];
          r_ctrl_wr[i] <= 1'b1;
        end else begin
          r_ctrl_wr[i] <= 1'b0;
        end
      end
    end
  end

  // Read response registers, held until the R handshake.
  always_ff @(posedge S_ACLK) begin
    if (S_ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && S_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile (default 32-bit, 4 ctrl / 2 stat).
module tb_axil_regfile;

  logic         clk;
  logic         rst;
  logic [127:0] ctrl;
  logic [3:0]   ctrl_wr;
  logic [63:0]  stat;
  logic [5:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [5:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] EXP_UNMAPPED_RESP = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAPPED_RESP = 2'b00;
`endif

  axil_regfile dut (
    .S_ACLK   (clk),
    .S_ARESET (rst),
    .CTRL     (ctrl),
    .CTRL_WR  (ctrl_wr),
    .STAT     (stat),
    .S_AWADDR (awaddr),
    .S_AWPROT (awprot),
    .S_AWVALID(awvalid),
    .S_AWREADY(awready),
    .S_WDATA  (wdata),
    .S_WSTRB  (wstrb),
    .S_WVALID (wvalid),
    .S_WREADY (wready),
    .S_BRESP  (bresp),
    .S_BVALID (bvalid),
    .S_BREADY (bready),
    .S_ARADDR (araddr),
    .S_ARPROT (arprot),
    .S_ARVALID(arvalid),
    .S_ARREADY(arready),
    .S_RDATA  (rdata),
    .S_RRESP  (rresp),
    .S_RVALID (rvalid),
    .S_RREADY (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stat = 64'h0; awaddr = 6'h0; awprot = 3'b000; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    araddr = 6'h0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    tick();
    tick();
    chk("rst_ctrl", ctrl, 128'h0);
    chk("rst_ready_in_reset", {awready, wready, arready}, 3'b111);
    rst = 1'b0;
    tick();
    chk("rst_valids", {bvalid, rvalid, ctrl_wr}, 6'b0);
    chk("rst_resp", {bresp, rresp, rdata}, 36'h0);

    // Same-cycle AW and W.
    awaddr = 6'h00; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("w0_ctrl0", ctrl[31:0], 32'h12345678);
    chk("w0_ctrl_wr", ctrl_wr, 4'b0001);
    chk("w0_b", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    tick();
    chk("w0_b_done", {bvalid, ctrl_wr}, 5'b0);
    bready = 1'b0;

    // AW in cycle 0, strobed W in cycle 3.
    awaddr = 6'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("w1_aw_held", {awready, wready, bvalid}, 3'b010);
    tick();
    tick();
    wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
    chk("w1_no_b_yet", bvalid, 1'b0);
    tick();
    wvalid = 1'b0;
    chk("w1_ctrl2", ctrl[95:64], 32'h00BB00DD);
    chk("w1_ctrl_wr", ctrl_wr, 4'b0100);
    chk("w1_b", {bvalid, bresp}, 3'b100);

    // B back-pressure with a second AW pending.
    awaddr = 6'h04; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", bvalid, 1'b1);
      chk("bp_readies", {awready, wready}, 2'b00);
      tick();
    end
    chk("bp_pulse_gone", ctrl_wr, 4'b0);
    bready = 1'b1;
    tick();
    chk("bp_b_done", bvalid, 1'b0);
    chk("bp_aw_ready_after", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    chk("bp_aw_taken", {awready, bvalid}, 2'b00);
    wdata = 32'h00000011; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("bp_ctrl1", ctrl[63:32], 32'h00000011);
    chk("bp_b", bvalid, 1'b1);
    tick();
    chk("bp_b2_done", bvalid, 1'b0);
    bready = 1'b0;

    // Status read, sampled on AR.
    stat = {32'h0000BEEF, 32'hCAFE0001};
    araddr = 6'h10; arvalid = 1'b1;
    chk("rd_arready", {arready, rvalid}, 2'b10);
    tick();
    arvalid = 1'b0;
    stat[31:0] = 32'h0;
    chk("rd_stat0", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hCAFE0001});
    chk("rd_arready_busy", arready, 1'b0);
    tick();
    chk("rd_hold", {rvalid, rdata}, {1'b1, 32'hCAFE0001});
    rready = 1'b1;
    tick();
    chk("rd_done", rvalid, 1'b0);

    // Write to status is discarded.
    awaddr = 6'h10; awvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wstat_ctrl", ctrl, {32'h0, 32'h00BB00DD, 32'h00000011, 32'h12345678});
    chk("wstat_b", {bvalid, bresp, ctrl_wr}, {1'b1, 2'b00, 4'b0});
    tick();

    // Read and write CTRL[1] on the same edge.
    araddr = 6'h04; arvalid = 1'b1;
    awaddr = 6'h04; awvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("rw_old", {rvalid, rdata}, {1'b1, 32'h00000011});
    chk("rw_ctrl1", ctrl[63:32], 32'h5);
    chk("rw_b", bvalid, 1'b1);
    tick();
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rw_new", {rvalid, rdata}, {1'b1, 32'h5});
    tick();

    // Unmapped index 7.
    araddr = 6'h1C; arvalid = 1'b1;
    awaddr = 6'h1C; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("um_r", {rvalid, rresp, rdata}, {1'b1, EXP_UNMAPPED_RESP, 32'h0});
    chk("um_b", {bvalid, bresp}, {1'b1, EXP_UNMAPPED_RESP});
    chk("um_ctrl", {ctrl, ctrl_wr}, {32'h0, 32'h00BB00DD, 32'h00000005, 32'h12345678, 4'b0});
    tick();

    // Reset mid-transaction drops held AW and pending R.
    rready = 1'b0;
    awaddr = 6'h00; awvalid = 1'b1; araddr = 6'h00; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("mr_pending", {awready, rvalid}, 2'b01);
    rst = 1'b1;
    tick();
    chk("mr_cleared", {ctrl, rvalid, bvalid, awready, wready}, {128'h0, 4'b0011});
    rst = 1'b0;
    tick();
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("mr_no_commit", {bvalid, wready, ctrl_wr, ctrl}, {2'b00, 4'b0, 128'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
